// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized serial input, mid-bit sampling, and a held
// output word with rxValid / overrun / frame-error reporting.
module uart_receiver #(
  parameter int DVSR      = 347,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 serialIn,
  input  logic                 rdAck,
  output logic [WORD_SIZE-1:0] dataOut,
  output logic                 rxValid,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 busy
);
  localparam int TW = $clog2(DVSR);
  localparam int BW = $clog2(WORD_SIZE + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(DVSR / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(DVSR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, sIn;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick_done, frame_good, frame_bad;

  assign sIn        = sync2_q;
  assign tick_done  = (tick_q == '0);
  assign frame_good = (state_q == STOP) && tick_done && sIn;
  assign frame_bad  = (state_q == STOP) && tick_done && !sIn;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= serialIn;
      sync2_q <= sync1_q;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Leaving STOP straight to IDLE lets a start edge in the late stop bit be caught.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!sIn) state_d = START;
      START:     if (tick_done) state_d = sIn ? IDLE : DATA;
      DATA:      if (tick_done && (bit_q == LAST_BIT)) state_d = STOP;
      STOP:      if (tick_done) state_d = sIn ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (sIn) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        tick_d = HALF_M1;
        bit_d  = '0;
      end
      START, STOP: tick_d = tick_done ? FULL_M1 : tick_q - 1'b1;
      DATA: begin
        if (tick_done) begin
          tick_d  = FULL_M1;
          bit_d   = bit_q + 1'b1;
          shift_d = WORD_SIZE'({sIn, shift_q} >> 1);
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      default: ;
    endcase

    // A completing frame takes priority over an acknowledge in the same cycle.
    data_d = frame_good ? shift_q : data_q;
    ferr_d = frame_bad;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (frame_good) begin
      vld_d = 1'b1;
      if (vld_q) ovr_d = !rdAck;
    end else if (rdAck && vld_q) begin
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_comb begin
    dataOut  = data_q;
    rxValid  = vld_q;
    frameErr = ferr_q;
    overrun  = ovr_q;
    busy     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level reference model (completion events keyed by
// cycle) compared every cycle, plus directed scenarios with literal expectations.
module tb_uart_receiver;
  localparam int D       = 347;
  localparam int W       = 8;
  localparam int H       = D / 2;
  localparam int LAT     = 2 + D / 2 + (W + 1) * D + 1;
  localparam int LAT_LIT = 3299;

  logic         clk, nRST, serialIn, rdAck;
  logic [W-1:0] dataOut;
  logic         rxValid, frameErr, overrun, busy;

  uart_receiver #(.DVSR(D), .WORD_SIZE(W)) dut (
    .clk(clk), .nRST(nRST), .serialIn(serialIn), .rdAck(rdAck),
    .dataOut(dataOut), .rxValid(rxValid), .frameErr(frameErr),
    .overrun(overrun), .busy(busy)
  );

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           ev_kind [int];
  logic [W-1:0] ev_data [int];
  bit           ack_set [int];
  bit           rnd_ack = 0;
  logic         e_vld = 0, e_ovr = 0, e_ferr = 0;
  logic [W-1:0] e_data = '0;
  logic         prev_vld = 0;
  int           rise_cyc = 0;
  int           ferr_cnt = 0;
  logic [W-1:0] rise_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: frame outcomes land on their completion cycle; rdAck rules applied per edge.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (!nRST) begin
      e_vld = 0; e_ovr = 0; e_ferr = 0; e_data = '0;
    end else begin
      e_ferr = ev_kind.exists(cyc) && (ev_kind[cyc] == 2);
      if (ev_kind.exists(cyc) && (ev_kind[cyc] == 1)) begin
        if (e_vld) e_ovr = !rdAck;
        e_data = ev_data[cyc];
        e_vld  = 1;
      end else if (rdAck && e_vld) begin
        e_vld = 0;
        e_ovr = 0;
      end
    end
  end

  initial begin
    rdAck = 1'b0;
    forever begin
      @(posedge clk); #1;
      rdAck = ack_set.exists(cyc + 1) || (rnd_ack && ($urandom_range(0, 2999) == 0));
    end
  end

  initial forever begin
    @(negedge clk);
    if (nRST) begin
      chk("cmp_rxValid", 32'(rxValid), 32'(e_vld));
      chk("cmp_dataOut", 32'(dataOut), 32'(e_data));
      chk("cmp_overrun", 32'(overrun), 32'(e_ovr));
      chk("cmp_frameErr", 32'(frameErr), 32'(e_ferr));
      if (rxValid && !prev_vld) begin
        rise_cyc = cyc;
        rise_q.push_back(dataOut);
      end
      if (frameErr) ferr_cnt++;
      prev_vld = rxValid;
    end else begin
      prev_vld = 0;
    end
  end

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stopb, input int ack_off,
                            output int s);
    s = cyc;
    if (stopb) begin
      ev_kind[s + LAT] = 1;
      ev_data[s + LAT] = d;
    end else begin
      ev_kind[s + LAT] = 2;
    end
    if (ack_off >= 0) ack_set[s + LAT + ack_off] = 1;
    serialIn = 1'b0;
    tick(D);
    for (int i = 0; i < W; i++) begin
      serialIn = d[i];
      tick(D);
    end
    serialIn = stopb;
    tick(D);
  endtask

  initial begin
    int s, n0, f0, r, ao;
    logic [W-1:0] d, bf;
    logic stopb;

    nRST = 1'b1;
    serialIn = 1'b1;
    #2 nRST = 1'b0;
    #1;
    chk("rst_dataOut", 32'(dataOut), 32'h0);
    chk("rst_rxValid", 32'(rxValid), 32'h0);
    chk("rst_frameErr", 32'(frameErr), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 nRST = 1'b1;
    tick(5);

    // Single frame: latency and acknowledge
    send_frame(8'hAB, 1'b1, -1, s);
    tick(20);
    chk("ab_latency", 32'(rise_cyc - s), 32'(LAT_LIT));
    chk("ab_dataOut", 32'(dataOut), 32'hAB);
    chk("ab_rxValid", 32'(rxValid), 32'h1);
    chk("ab_overrun", 32'(overrun), 32'h0);
    chk("ab_no_ferr", 32'(ferr_cnt), 32'h0);
    ack_set[cyc + 2] = 1;
    tick(4);
    chk("ab_ack_rxValid", 32'(rxValid), 32'h0);

    // Back-to-back frames with an acknowledge after each
    n0 = rise_q.size();
    send_frame(8'hA1, 1'b1, 10, s);
    send_frame(8'hA0, 1'b1, 10, s);
    send_frame(8'hD0, 1'b1, 10, s);
    tick(20);
    chk("b2b_count", 32'(rise_q.size() - n0), 32'd3);
    chk("b2b_word0", 32'(rise_q[n0]), 32'hA1);
    chk("b2b_word1", 32'(rise_q[n0 + 1]), 32'hA0);
    chk("b2b_word2", 32'(rise_q[n0 + 2]), 32'hD0);
    chk("b2b_overrun", 32'(overrun), 32'h0);

    // Five-cycle low glitch
    n0 = rise_q.size();
    serialIn = 1'b0;
    tick(5);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    serialIn = 1'b1;
    tick(H + 3 - 5);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_rxValid", 32'(rxValid), 32'h0);
    tick(20);
    chk("glitch_no_word", 32'(rise_q.size() - n0), 32'd0);

    // Bad stop bit, line held low, then recovery
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, -1, s);
    tick(D);
    chk("ferr_busy_low", 32'(busy), 32'h1);
    chk("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_dataOut", 32'(dataOut), 32'hD0);
    chk("ferr_rxValid", 32'(rxValid), 32'h0);
    tick(D);
    serialIn = 1'b1;
    tick(5);
    chk("ferr_busy_idle", 32'(busy), 32'h0);
    tick(D);
    n0 = rise_q.size();
    send_frame(8'h3C, 1'b1, 10, s);
    tick(20);
    chk("after_ferr_word", 32'(rise_q[n0]), 32'h3C);

    // Overrun, then acknowledge coincident with completion
    send_frame(8'h11, 1'b1, -1, s);
    tick(50);
    send_frame(8'h22, 1'b1, -1, s);
    tick(20);
    chk("ovr_dataOut", 32'(dataOut), 32'h22);
    chk("ovr_set", 32'(overrun), 32'h1);
    chk("ovr_rxValid", 32'(rxValid), 32'h1);
    ack_set[cyc + 2] = 1;
    tick(4);
    chk("ovr_ack_rxValid", 32'(rxValid), 32'h0);
    chk("ovr_ack_overrun", 32'(overrun), 32'h0);
    send_frame(8'h11, 1'b1, -1, s);
    tick(50);
    send_frame(8'h22, 1'b1, 0, s);
    tick(20);
    chk("coinc_overrun", 32'(overrun), 32'h0);
    chk("coinc_rxValid", 32'(rxValid), 32'h1);
    chk("coinc_dataOut", 32'(dataOut), 32'h22);
    ack_set[cyc + 2] = 1;
    tick(4);

    // Randomized frames, stop bits, gaps and acknowledges
    rnd_ack = 1;
    for (int k = 0; k < 6; k++) begin
      d = W'($urandom);
      stopb = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 3);
      ao = (r == 0) ? 0 : ((r == 1) ? $urandom_range(1, 60) : -1);
      send_frame(d, stopb, ao, s);
      if (!stopb) begin
        tick($urandom_range(1, D));
        serialIn = 1'b1;
        tick($urandom_range(10, 100));
      end else if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(1, 300));
      end
    end
    rnd_ack = 0;
    tick(10);
    ack_set[cyc + 2] = 1;
    tick(4);
    chk("rnd_final_rxValid", 32'(rxValid), 32'h0);
    chk("rnd_final_overrun", 32'(overrun), 32'h0);

    // Reset in the middle of the data bits of 0xF0
    bf = 8'hF0;
    serialIn = 1'b0;
    tick(D);
    for (int i = 0; i < 5; i++) begin
      serialIn = bf[i];
      tick(D);
    end
    serialIn = bf[5];
    tick(H);
    chk("mid_busy", 32'(busy), 32'h1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_dataOut", 32'(dataOut), 32'h0);
    chk("mid_rst_rxValid", 32'(rxValid), 32'h0);
    chk("mid_rst_frameErr", 32'(frameErr), 32'h0);
    chk("mid_rst_overrun", 32'(overrun), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    serialIn = 1'b1;
    repeat (3) @(posedge clk);
    #1 nRST = 1'b1;
    tick(D);
    chk("post_rst_idle", 32'(busy), 32'h0);
    n0 = rise_q.size();
    send_frame(8'h0F, 1'b1, -1, s);
    tick(20);
    chk("post_rst_word", 32'(rise_q[n0]), 32'h0F);
    chk("post_rst_dataOut", 32'(dataOut), 32'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DVSR, default 347: clk cycles per bit period (40 MHz / 347 ~ 115200 baud); minimum legal value 4.
REQ-002 Parameter WORD_SIZE, default 8: data bits per frame.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  asynchronous, active-low reset.
REQ-005 serialIn  input  1  asynchronous serial line; idle high.
REQ-006 rdAck  input  1  consumer acknowledge; one-cycle pulse consumes the held word.
REQ-007 dataOut  output  WORD_SIZE  last correctly framed word, held until the next good frame.
REQ-008 rxValid  output  1  high while an unconsumed word is held in dataOut.
REQ-009 frameErr  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overrun  output  1  sticky flag: an unconsumed word was overwritten.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Frame format: 1 start bit (0), WORD_SIZE data bits LSB first, 1 stop bit (1), no parity.
REQ-013 serialIn passes through a 2-flop synchronizer reset to 1; all logic uses the synchronized value (sIn).
REQ-014 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: sIn==0 -> START; bit counter cleared; tick counter loaded for DVSR/2 (integer division) cycles.
REQ-016 START: when the half-bit count expires, sample sIn; 1 -> IDLE (glitch rejected, no outputs change); 0 -> DATA with a full DVSR-cycle count.
REQ-017 DATA: every DVSR cycles sample sIn into the shift register (LSB first); after WORD_SIZE samples -> STOP with a DVSR-cycle count.
REQ-018 Sample points fall at mid-bit: start + DVSR/2, then every DVSR cycles thereafter.
REQ-019 STOP at the sample: sIn==1 -> load dataOut, set rxValid, go to IDLE in the same cycle, so a start edge during the second half of the stop bit is accepted (back-to-back frames).
REQ-020 STOP at the sample: sIn==0 -> frameErr high for exactly one cycle, dataOut and rxValid unchanged, -> WAIT_IDLE.
REQ-021 WAIT_IDLE: remain until sIn==1, then -> IDLE (break/low-line lockout).
REQ-022 dataOut and rxValid update on the clock edge after the stop sample; overall latency from the serialIn start-bit edge is 2 + DVSR/2 + (WORD_SIZE+1)*DVSR + 1 cycles.
REQ-023 rdAck while rxValid==1: clear rxValid and overrun next cycle; rdAck while rxValid==0 is ignored.
REQ-024 Good frame completes while rxValid==1 and rdAck==0: overwrite dataOut, keep rxValid=1, set overrun=1.
REQ-025 Good frame completes in the same cycle as rdAck: load new dataOut, rxValid stays 1, overrun cleared (not set).
REQ-026 Tick and bit counters are sized as $clog2(DVSR) and $clog2(WORD_SIZE+1) bits; no wrap-around occurs within a frame.

Reset
REQ-027 nRST low asynchronously forces: state=IDLE, counters=0, shift register=0, dataOut=0, rxValid=0, frameErr=0, overrun=0, busy=0, synchronizer flops=1.
REQ-028 Reset asserted mid-frame discards the partial frame; after release, reception resumes only on a new falling edge of sIn.

Verification
REQ-029 DVSR=347: drive frame 0xAB -> dataOut=0xAB, rxValid=1 at the REQ-022 latency (+/-1 cycle), frameErr=0, overrun=0; rdAck pulse -> rxValid=0.
REQ-030 Send 0xA1, 0xA0, 0xD0 back-to-back with one stop bit each, pulsing rdAck after each -> three rxValid assertions with the matching data, no overrun.
REQ-031 Low glitch of 5 cycles on serialIn -> returns to IDLE, rxValid stays 0, busy deasserts within DVSR/2+3 cycles.
REQ-032 Frame 0x55 with stop bit 0, line held low 2*DVSR cycles -> single-cycle frameErr, dataOut unchanged, busy=1 until line high; next good frame 0x3C received correctly.
REQ-033 Frames 0x11 then 0x22 with no rdAck -> dataOut=0x22, overrun=1; rdAck -> rxValid=0, overrun=0; repeat with rdAck coincident with the second completion -> overrun stays 0.
REQ-034 nRST pulsed low mid-DATA of 0xF0 -> all outputs 0 immediately; the subsequent frame 0x0F -> dataOut=0x0F.
